// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS DATA_WIDTH-bit registers with byte strobes.
// Independent one-entry AW/W buffers, a single outstanding B and R response each.
module axi_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_WIDTH);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic                 wr_in_range, rd_in_range;
  logic [IDX_WIDTH-1:0] wr_idx, rd_idx;

  assign aw_ready = rst_n & ~aw_full;
  assign w_ready  = rst_n & ~w_full;
  assign ar_ready = rst_n & ~r_valid;

  assign aw_hs  = aw_valid & aw_ready;
  assign w_hs   = w_valid & w_ready;
  assign ar_hs  = ar_valid & ar_ready;
  // A pending response blocks the next commit so b_resp never changes under the master.
  assign commit = aw_full & w_full & ~b_valid;

  assign wr_in_range = aw_addr_q < ADDR_LIMIT;
  assign rd_in_range = ar_addr < ADDR_LIMIT;
  assign wr_idx      = aw_addr_q[ADDR_LSB +: IDX_WIDTH];
  assign rd_idx      = ar_addr[ADDR_LSB +: IDX_WIDTH];

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values; this is also what makes a same-edge read return the old data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_addr_q <= aw_addr;
      end else if (commit) begin
        aw_full <= 1'b0;
      end

      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end else if (commit) begin
        w_full <= 1'b0;
      end

      if (commit) begin
        b_valid <= 1'b1;
        b_resp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

  // NOTE: the register array is reset explicitly, so it maps to flops rather
  // than a RAM macro; software relies on every register reading 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_q[b]) regs[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= rd_in_range ? regs[rd_idx] : '0;
      r_resp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_ready) begin
      r_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (32-bit data, 8 registers) with
// hand-computed expectations checked by immediate assertions.
module tb_axi_lite_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  aw_addr;
  logic         aw_valid;
  logic         aw_ready;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         w_valid;
  logic         w_ready;
  logic [1:0]   b_resp;
  logic         b_valid;
  logic         b_ready;
  logic [31:0]  ar_addr;
  logic         ar_valid;
  logic         ar_ready;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic         r_valid;
  logic         r_ready;
  logic [255:0] regs_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_regs [8];

  axi_lite_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = exp_regs[i];
    return v;
  endfunction

  // Same-cycle AW/W, response expected exactly one edge after the handshake edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string tag);
    int n;
    aw_addr = addr; aw_valid = 1'b1;
    w_data = data; w_strb = strb; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!b_valid && n < 8);
    check({tag, "_b_valid"}, 256'(b_valid), 256'(1));
    check({tag, "_latency"}, 256'(n), 256'(1));
    check({tag, "_b_resp"}, 256'(b_resp), 256'(exp_resp));
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    ar_addr = addr; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    check({tag, "_r_valid"}, 256'(r_valid), 256'(1));
    check({tag, "_r_data"}, 256'(r_data), 256'(exp_data));
    check({tag, "_r_resp"}, 256'(r_resp), 256'(exp_resp));
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check({tag, "_r_clear"}, 256'(r_valid), 256'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    aw_addr = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;

    // Reset state
    step();
    step();
    check("rst_aw_ready", 256'(aw_ready), 256'(0));
    check("rst_w_ready", 256'(w_ready), 256'(0));
    check("rst_ar_ready", 256'(ar_ready), 256'(0));
    check("rst_b_valid", 256'(b_valid), 256'(0));
    check("rst_r_valid", 256'(r_valid), 256'(0));
    check("rst_regs", regs_o, 256'(0));
    rst_n = 1'b1;
    #1;
    check("rel_aw_ready", 256'(aw_ready), 256'(1));
    check("rel_w_ready", 256'(w_ready), 256'(1));
    check("rel_ar_ready", 256'(ar_ready), 256'(1));

    // Basic write/read to register 1
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 2'b00, "basic_wr");
    exp_regs[1] = 32'hDEADBEEF;
    check("basic_slice1", 256'(regs_o[63:32]), 256'(32'hDEADBEEF));
    axi_read(32'h04, 32'hDEADBEEF, 2'b00, "basic_rd");

    // Data before address: W waits three cycles for AW to register 2
    w_data = 32'h11223344; w_strb = 4'hF; w_valid = 1'b1;
    step();
    w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wfirst_w_ready", 256'(w_ready), 256'(0));
      check("wfirst_no_b", 256'(b_valid), 256'(0));
      step();
    end
    aw_addr = 32'h08; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    check("wfirst_b_early", 256'(b_valid), 256'(0));
    step();
    check("wfirst_b_valid", 256'(b_valid), 256'(1));
    check("wfirst_b_resp", 256'(b_resp), 256'(0));
    exp_regs[2] = 32'h11223344;
    check("wfirst_regs", regs_o, model_flat());
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;

    // Partial strobe and zero strobe on register 3
    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, 2'b00, "strb_full");
    axi_write(32'h0C, 32'h00001234, 4'h3, 2'b00, "strb_low");
    check("strb_slice3", 256'(regs_o[127:96]), 256'(32'hFFFF1234));
    axi_write(32'h0C, 32'h0BAD0BAD, 4'h0, 2'b00, "strb_zero");
    exp_regs[3] = 32'hFFFF1234;
    check("strb_regs", regs_o, model_flat());
    axi_read(32'h0E, 32'hFFFF1234, 2'b00, "low_bits_ignored");

    // Out of range, including the first address past the last register
    axi_write(32'h40, 32'h55AA55AA, 4'hF, 2'b10, "oor_wr");
    axi_write(32'h20, 32'h55AA55AA, 4'hF, 2'b10, "oor_edge_wr");
    check("oor_regs", regs_o, model_flat());
    axi_read(32'h40, 32'h0, 2'b10, "oor_rd");
    axi_write(32'h1C, 32'hCAFEF00D, 4'hF, 2'b00, "last_reg_wr");
    exp_regs[7] = 32'hCAFEF00D;
    check("last_reg_regs", regs_o, model_flat());

    // Write backpressure: B held 5 cycles with a second write queued
    aw_addr = 32'h10; aw_valid = 1'b1;
    w_data = 32'hAAAA0001; w_strb = 4'hF; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    step();
    exp_regs[4] = 32'hAAAA0001;
    aw_addr = 32'h14; aw_valid = 1'b1;
    w_data = 32'hBBBB0002; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_b_valid", 256'(b_valid), 256'(1));
      check("bp_b_resp", 256'(b_resp), 256'(0));
      check("bp_blocked", 256'(regs_o[191:160]), 256'(0));
      step();
    end
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;
    check("bp_b_clear", 256'(b_valid), 256'(0));
    check("bp_still_blocked", 256'(regs_o[191:160]), 256'(0));
    step();
    exp_regs[5] = 32'hBBBB0002;
    check("bp_second_b", 256'(b_valid), 256'(1));
    check("bp_regs", regs_o, model_flat());
    b_ready = 1'b1;
    step();
    b_ready = 1'b0;

    // Read backpressure: R held while a new AR is offered
    ar_addr = 32'h10; ar_valid = 1'b1;
    step();
    ar_addr = 32'h04;
    for (int i = 0; i < 3; i++) begin
      check("rbp_r_valid", 256'(r_valid), 256'(1));
      check("rbp_r_data", 256'(r_data), 256'(32'hAAAA0001));
      check("rbp_ar_ready", 256'(ar_ready), 256'(0));
      step();
    end
    ar_valid = 1'b0; r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    check("rbp_r_clear", 256'(r_valid), 256'(0));
    check("rbp_ar_ready_back", 256'(ar_ready), 256'(1));

    // Read and write commit to register 4 on the same edge: old value returned
    aw_addr = 32'h10; aw_valid = 1'b1;
    w_data = 32'hCCCC0003; w_strb = 4'hF; w_valid = 1'b1;
    step();
    aw_valid = 1'b0; w_valid = 1'b0;
    ar_addr = 32'h10; ar_valid = 1'b1;
    step();
    ar_valid = 1'b0;
    exp_regs[4] = 32'hCCCC0003;
    check("raw_r_data", 256'(r_data), 256'(32'hAAAA0001));
    check("raw_b_valid", 256'(b_valid), 256'(1));
    check("raw_regs", regs_o, model_flat());
    b_ready = 1'b1; r_ready = 1'b1;
    step();
    b_ready = 1'b0; r_ready = 1'b0;

    // Reset with AW accepted and W pending
    aw_addr = 32'h18; aw_valid = 1'b1;
    step();
    aw_valid = 1'b0;
    check("mid_aw_full", 256'(aw_ready), 256'(0));
    rst_n = 1'b0;
    step();
    check("mid_aw_ready", 256'(aw_ready), 256'(0));
    check("mid_w_ready", 256'(w_ready), 256'(0));
    check("mid_ar_ready", 256'(ar_ready), 256'(0));
    check("mid_b_valid", 256'(b_valid), 256'(0));
    check("mid_b_resp", 256'(b_resp), 256'(0));
    check("mid_r_valid", 256'(r_valid), 256'(0));
    check("mid_r_data", 256'(r_data), 256'(0));
    check("mid_regs", regs_o, 256'(0));
    rst_n = 1'b1;
    #1;
    check("mid_rel_aw_ready", 256'(aw_ready), 256'(1));
    check("mid_rel_w_ready", 256'(w_ready), 256'(1));
    check("mid_rel_ar_ready", 256'(ar_ready), 256'(1));
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;
    axi_write(32'h1C, 32'h12345678, 4'hF, 2'b00, "post_rst_wr");
    exp_regs[7] = 32'h12345678;
    check("post_rst_regs", regs_o, model_flat());
    axi_read(32'h18, 32'h0, 2'b00, "post_rst_rd6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width, restricted to 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, the register count, a power of two from 2 to 256.
REQ-004 SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-005 Ports, in order:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- aw_addr  in  ADDR_WIDTH  write address.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address ready.
- w_data  in  DATA_WIDTH  write data.
- w_strb  in  DATA_WIDTH/8  byte strobes.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data ready.
- b_resp  out  2  write response.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response ready.
- ar_addr  in  ADDR_WIDTH  read address.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address ready.
- r_data  out  DATA_WIDTH  read data.
- r_resp  out  2  read response.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data ready.
- regs_o  out  NUM_REGS*DATA_WIDTH  register contents; register i is at slice i.

Function
REQ-006 SHALL map register i to byte address i*(DATA_WIDTH/8).
- Address bits below log2(DATA_WIDTH/8) are ignored.
- An address >= NUM_REGS*(DATA_WIDTH/8) is out of range.
REQ-007 SHALL hold AW and W in independent one-entry buffers, aw_full and w_full.
- aw_ready = rst_n AND NOT aw_full.
- w_ready = rst_n AND NOT w_full.
- AW and W may arrive in either order, or in the same cycle.
REQ-008 SHALL commit a write on a rising edge where aw_full AND w_full AND NOT b_valid. At that edge:
- update the bytes enabled by w_strb;
- clear aw_full and w_full;
- set b_valid.
REQ-009 Write latency: AW and W handshakes at edge N give a commit and b_valid=1 at edge N+1.
REQ-010 b_resp SHALL be 2'b00 (OKAY) for an in-range write and 2'b10 (SLVERR) for an out-of-range write; an out-of-range write modifies no register.
REQ-011 b_valid SHALL stay high, with b_resp stable, until the edge where b_ready=1, then clear.
- A commit blocked by a pending b_valid occurs at the edge after the B handshake.
REQ-012 w_strb=0 in range SHALL leave the register unchanged and return OKAY.
REQ-013 ar_ready SHALL equal rst_n AND NOT r_valid.
- An AR handshake at edge N registers r_data, r_resp and r_valid=1 at edge N.
REQ-014 In-range reads SHALL return the register value with r_resp=2'b00.
- Out-of-range reads SHALL return r_data=0 with r_resp=2'b10.
REQ-015 r_valid, r_data and r_resp SHALL hold stable until the edge where r_ready=1.
REQ-016 A read and a write commit to the same register on the same edge SHALL return the pre-write value.
REQ-017 Read and write paths SHALL operate concurrently and independently.
REQ-018 regs_o SHALL reflect register contents one edge after commit, with no combinational path from any input.

Reset
REQ-019 At an edge with rst_n=0, SHALL clear all of the following to 0, discarding any in-flight transaction: registers, aw_full, w_full, b_valid, b_resp, r_valid, r_data, r_resp.
REQ-020 While rst_n=0, aw_ready, w_ready and ar_ready SHALL be 0; they SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-021 Basic write/read: AW 0x04 and W 0xDEADBEEF strb 0xF in the same cycle -> b_valid one cycle later, b_resp=00; read 0x04 -> r_data=0xDEADBEEF, r_resp=00; regs_o slice 1 = 0xDEADBEEF.
REQ-022 Data before address: W 0x11223344 accepted, AW 0x08 arrives 3 cycles later -> w_ready=0 in between; commit one edge after AW; register 2 = 0x11223344.
REQ-023 Partial strobe: register 3 = 0xFFFFFFFF, write 0x00001234 strb 0x3 -> register 3 = 0xFFFF1234.
REQ-024 Out of range: write 0x40 -> b_resp=10 and no register changes; read 0x40 -> r_data=0, r_resp=10.
REQ-025 Backpressure: b_ready=0 for 5 cycles with a second AW/W queued -> b_valid held with b_resp stable; second commit occurs one edge after the B handshake. Also r_ready=0 -> r_data held and ar_ready=0.
REQ-026 Reset mid-transaction: AW accepted, W pending, rst_n=0 for one edge -> all outputs 0 and no write; after release, readies=1 and a fresh write completes normally.
